icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (icache_addr/icache_data/icache_rdy) and the instruction memory bus.
- Hits return the addressed word combinationally in the same cycle.
- Misses stall fetch (rdy low) while a whole line is refilled by a multi-beat req/ack handshake.
- A global invalidate supports fence.i / program reload.

Parameters:
- LINES, 16, number of cache lines (power of 2, >=2)
- WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored
- cpu_data  out  32  instruction word; 0 whenever cpu_rdy=0
- cpu_rdy  out  1  cpu_data valid for cpu_addr this cycle
- invalidate  in  1  clear all valid bits
- mem_addr  out  32  word-aligned refill address
- mem_req  out  1  refill beat request
- mem_rdata  in  32  refill data, valid with mem_ack
- mem_ack  in  1  beat accepted; mem_rdata captured this edge

Behaviour:
- Address split:
  - offset = cpu_addr[2+log2(WORDS)-1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per-line valid bit, tag register and WORDS data words, all flops (no SRAM).
- States: IDLE, REFILL.
- Hit:
  - hit = (state==IDLE) && valid[index] && tag match.
  - cpu_rdy = hit; cpu_data = data[index][offset] when hit, else 0. Both combinational, zero-cycle latency.
- IDLE, miss, invalidate=0:
  - Next edge: latch line base (cpu_addr with offset and byte bits zeroed), beat=0, mem_addr=base, mem_req=1, state=REFILL.
  - valid[index] cleared at the same edge.
- REFILL:
  - mem_req and mem_addr stay stable until mem_ack.
  - On a mem_ack edge: write mem_rdata into data[latched index][beat]; beat++; mem_addr += 4.
  - On the last beat (beat==WORDS-1): mem_req=0, tag written, valid set (unless killed), state=IDLE.
  - cpu_rdy=0 throughout REFILL. The earliest hit is the cycle after the last ack.
- Refill latency with zero-wait memory (ack in the first req cycle):
  - 1 cycle to issue + WORDS beats.
  - Total miss penalty WORDS+1 cycles from the miss cycle to the first rdy.
- cpu_addr changing during REFILL: ignored. The latched line completes; a new lookup happens in IDLE.
- mem_ack while mem_req=0: ignored.
- Invalidate:
  - In IDLE: all valid bits cleared at the next edge. A miss in that same cycle starts no refill, and cpu_rdy is forced 0 that cycle.
  - In REFILL: all valid bits cleared. A kill flag is set so the in-flight line is not marked valid on completion; kill is cleared on return to IDLE.
- Reset (async, at any time, including mid-refill):
  - state=IDLE, all valid=0, beat=0, kill=0, mem_req=0, mem_addr=0.
  - Hence cpu_rdy=0 and cpu_data=0.
  - The aborted refill is dropped; a mem_ack arriving after reset deasserts is ignored.
- Tag/data contents are not reset; they are unobservable while valid=0.

Test Plan:
- Reset, cpu_addr=0x100, memory returns word=addr^0xA5A5A5A5 with ack every cycle:
  - Cycle 0: rdy=0, data=0.
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C with req high 4 cycles.
  - Cycle 5: rdy=1, data=0xA5A5A4A5.
- After the fill above, cpu_addr=0x108 and 0x10C:
  - Immediate rdy=1, no mem_req.
  - data=0xA5A5A4AD and 0xA5A5A4A9.
- Conflict: fill 0x100, then cpu_addr=0x100+LINES*WORDS*4=0x200 (same index):
  - Miss, refill 0x200-0x20C.
  - Then 0x100 misses again.
- Memory ack delayed 3 cycles per beat:
  - mem_addr/req held stable while waiting.
  - Refill takes 16 beat-cycles.
  - cpu_addr toggled during refill has no effect.
- Invalidate pulse in IDLE after a fill: the next fetch of 0x100 misses. Pulse mid-refill: the line completes but the following fetch still misses and refills.
- Reset asserted during beat 2 of a refill:
  - req=0, rdy=0 immediately.
  - A stray ack after release is ignored.
  - The next fetch performs a full refill from beat 0.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface icache_dm_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_rdy;
  logic        invalidate;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_addr, invalidate, mem_rdata, mem_ack,
    output cpu_data, cpu_rdy, mem_addr, mem_req
  );

  modport master (
    output cpu_addr, invalidate, mem_rdata, mem_ack,
    input  cpu_data, cpu_rdy, mem_addr, mem_req
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hits, whole-line
// refill over a req/ack bus, and a global invalidate for fence.i.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic        clock,
  input logic        reset,
  icache_dm_if.slave bus
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int IDX_LO = 2 + OFF_W;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [OFF_W-1:0]   beat;
  logic               kill;
  logic               mem_req;
  logic [31:0]        mem_addr;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES][WORDS];

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               fill_beat;
  logic               last_beat;
  logic               unused_byte_bits;

  assign cpu_off = bus.cpu_addr[IDX_LO-1:2];
  assign cpu_idx = bus.cpu_addr[TAG_LO-1:IDX_LO];
  assign cpu_tag = bus.cpu_addr[31:TAG_LO];
  assign unused_byte_bits = ^bus.cpu_addr[1:0];

  // mem_addr only walks the offset bits, so it carries the line being filled.
  assign fill_idx = mem_addr[TAG_LO-1:IDX_LO];
  assign fill_tag = mem_addr[31:TAG_LO];

  assign fill_beat = (state == REFILL) && mem_req && bus.mem_ack;
  assign last_beat = (beat == OFF_W'(WORDS - 1));

  assign hit          = (state == IDLE) && valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign bus.cpu_rdy  = hit && !bus.invalidate;
  assign bus.cpu_data = bus.cpu_rdy ? data_mem[cpu_idx][cpu_off] : 32'h0;
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; later assignments in this block deliberately override
  // earlier ones (e.g. completion clears kill after invalidate sets it).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      beat     <= '0;
      kill     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.invalidate) begin
            valid <= '0;
          end else if (!hit) begin
            mem_addr         <= {bus.cpu_addr[31:IDX_LO], {IDX_LO{1'b0}}};
            beat             <= '0;
            mem_req          <= 1'b1;
            valid[cpu_idx]   <= 1'b0;
            state            <= REFILL;
          end
        end
        REFILL: begin
          if (bus.invalidate) begin
            valid <= '0;
            kill  <= 1'b1;
          end
          if (fill_beat) begin
            beat <= beat + OFF_W'(1);
            if (last_beat) begin
              mem_req         <= 1'b0;
              kill            <= 1'b0;
              valid[fill_idx] <= !(kill || bus.invalidate);
              state           <= IDLE;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are not reset; valid gates every read, and a
  // reset-free array maps onto plain enable flops without a reset tree.
  always_ff @(posedge clock) begin
    if (fill_beat) begin
      data_mem[fill_idx][beat] <= bus.mem_rdata;
      if (last_beat) begin
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

endmodule
